rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Picks one winner and drives a one-hot grant vector (decoded from the registered winner index) plus the 3-bit index.
- Holds the grant until the winner drops its request or a hold timeout expires.
- Sits in front of any shared datapath whose select lines are driven by a 3-to-8 one-hot decode.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, width of the grant index; log2(N_REQ).
- MAX_HOLD, 16, maximum cycles one grant may be held; legal range 2..65535.
- HOLD_W, 16, width of the hold counter; must hold MAX_HOLD.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high means requester i wants the resource.
- grant  output  8  one-hot grant; all zero when nothing is granted.
- grant_idx  output  3  index of the current grantee; 0 when grant_valid=0.
- grant_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset: sampled on the rising edge of clk while rst=1.
  - State=IDLE; grant=8'b0, grant_idx=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0; hold counter=0.
  - Reset mid-grant drops the grant at that same edge. It has priority over every other event.
- State machine: two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Else choose the winner w = first set bit of req, scanning ptr, ptr+1, ... wrapping modulo 8.
  - Next edge: GRANT, grant_idx=w, grant=1<<w, grant_valid=1, hold counter=1, ptr=(w+1) mod 8.
  - Latency: req sampled high in cycle t gives a grant visible in cycle t+1.
- GRANT:
  - Release: if req[grant_idx]==0, next edge returns to IDLE with grant=0, grant_valid=0, grant_idx=0.
  - Timeout: else if hold counter==MAX_HOLD, next edge returns to IDLE with grant cleared and timeout=1 for exactly that one cycle.
  - Else stay in GRANT and increment the hold counter.
  - Release takes priority over timeout when both would apply in the same cycle; timeout then stays 0.
- Turnaround: at least one IDLE cycle with grant_valid=0 between consecutive grants, including the same requester regranted. No back-to-back grants.
- Other requesters: req bits other than the grantee's are ignored while in GRANT.
- Pointer:
  - Updates only when a grant is issued; a timeout does not restore priority.
  - Wrap-around: w=7 gives ptr=0.
- Fairness: with req held at 8'hFF and each grantee releasing, the grant order is 0,1,2,...,7,0,...
- Invariants:
  - grant is always zero or one-hot, and equals 1<<grant_idx whenever grant_valid=1.
  - grant_valid==|grant.
  - timeout is never high while grant_valid=1.
- Hold accounting: the grant is visible for exactly MAX_HOLD cycles before forced revocation.
- Glitch-free: outputs change only on clk edges and never depend combinationally on req.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then rst=0 with req=0 for 10 cycles -> grant=0, grant_valid=0, grant_idx=0, timeout=0 throughout.
- Single request: req=8'b0010_0000 in cycle t, dropped at t+4 -> grant=8'b0010_0000, grant_idx=5 in cycles t+1..t+4; grant=0 at t+5; ptr=6 (check with req=8'hFF next: grant_idx=6).
- Round-robin fairness: req=8'hFF; each grantee drops its bit for one cycle after 2 granted cycles -> grant_idx sequence 0,1,2,3,4,5,6,7,0 with exactly one idle cycle between grants.
- Wrap and skip: after a grant to idx 6, req=8'b0000_0101 -> next grant idx 0; after release, next grant idx 2.
- Timeout with MAX_HOLD=4: req[3] held high, others 0 -> grant_idx=3 for 4 cycles; timeout=1 for one cycle with grant=0; idx 3 regranted the following cycle; pattern repeats.
- Reset mid-grant: assert rst during the 2nd granted cycle of idx 2 -> next edge grant=0, grant_valid=0, ptr=0; with req=8'b0000_0101 after reset, the next grant is idx 0.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters: grants one at a time, holds until the
// winner releases or MAX_HOLD cycles elapse, then always passes through IDLE.
module rr_grant_arbiter #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [HOLD_W-1:0]  hold, hold_nxt;
  logic               timeout_nxt;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W-1:0]   winner;

  // Rotating req so that bit 0 is the pointer position turns the circular
  // scan into a plain lowest-set-bit search.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[{1'b0, ptr} +: N_REQ];

  always_comb begin
    offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = IDX_W'(k);
    end
  end

  assign winner = ptr + offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      ptr     <= '0;
      hold    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      ptr     <= ptr_nxt;
      hold    <= hold_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    ptr_nxt     = ptr;
    hold_nxt    = hold;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt  = '0;
        hold_nxt = '0;
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = winner;
          hold_nxt  = HOLD_W'(1);
          ptr_nxt   = winner + IDX_W'(1);
        end
      end
      GRANT: begin
        // Release is checked first so a drop on the last allowed cycle is not a timeout.
        if (!req[idx]) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          hold_nxt  = '0;
        end else if (hold == HOLD_W'(MAX_HOLD)) begin
          state_nxt   = IDLE;
          idx_nxt     = '0;
          hold_nxt    = '0;
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    grant = '0;
    if (state == GRANT) grant[idx] = 1'b1;
  end

  assign grant_idx   = idx;
  assign grant_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: a cycle model feeds a scoreboard
// queue; directed phases also log grant order against fixed expectations.
module tb_rr_grant_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       t;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   want_log[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit m_busy = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_hold = 0;
  bit m_to   = 0;

  bit prev_valid  = 0;
  bit check_gap   = 0;
  bit seen_grant  = 0;
  int idle_run    = 0;
  int to_count    = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(
    .N_REQ(8), .IDX_W(3), .MAX_HOLD(MAX_HOLD), .HOLD_W(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .timeout(timeout)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Advances the model by one clock given the inputs about to be sampled.
  task automatic modelStep(input bit r, input logic [7:0] rq);
    exp_t e;
    bit   found;
    int   c;
    if (r) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      m_idx = 0;
      if (rq != 8'h00) begin
        found = 0;
        for (int k = 0; k < 8; k++) begin
          c = (m_ptr + k) % 8;
          if (!found && rq[c]) begin
            found = 1;
            m_idx = c;
          end
        end
        m_busy = 1;
        m_hold = 1;
        m_ptr  = (m_idx + 1) % 8;
      end
    end else if (!rq[m_idx]) begin
      m_busy = 0; m_idx = 0; m_hold = 0; m_to = 0;
    end else if (m_hold == MAX_HOLD) begin
      m_busy = 0; m_idx = 0; m_hold = 0; m_to = 1;
    end else begin
      m_hold++;
    end
    e.g = m_busy ? (8'h01 << m_idx) : 8'h00;
    e.i = 3'(m_idx);
    e.v = m_busy;
    e.t = m_to;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit r, input logic [7:0] rq);
    exp_t e;
    rst = r;
    req = rq;
    modelStep(r, rq);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput("grant", 16'(grant), 16'(e.g));
    checkOutput("grant_idx", 16'(grant_idx), 16'(e.i));
    checkOutput("grant_valid", 16'(grant_valid), 16'(e.v));
    checkOutput("timeout", 16'(timeout), 16'(e.t));
    if (timeout) to_count++;
    if (grant_valid && !prev_valid) begin
      grant_log.push_back(int'(grant_idx));
      if (check_gap && seen_grant) checkOutput("idle_gap", 16'(idle_run), 16'd1);
      seen_grant = 1;
      idle_run   = 0;
    end else if (!grant_valid) begin
      idle_run++;
    end
    prev_valid = grant_valid;
  endtask

  task automatic doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'h00);
    grant_log.delete();
    want_log.delete();
    seen_grant = 0;
    idle_run   = 0;
  endtask

  task automatic checkLog(input string tag);
    checkOutput({tag, "_count"}, 16'(grant_log.size()), 16'(want_log.size()));
    for (int k = 0; k < want_log.size() && k < grant_log.size(); k++)
      checkOutput($sformatf("%s[%0d]", tag, k), 16'(grant_log[k]), 16'(want_log[k]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rq;

    // Reset then a quiet bus
    doReset();
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 8'h00);

    // Single request held four cycles, then wrap and skip
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'b0010_0000);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'hFF);
    applyStimulus(1'b0, 8'b0000_0101);
    applyStimulus(1'b0, 8'b0000_0101);
    applyStimulus(1'b0, 8'b0000_0100);
    applyStimulus(1'b0, 8'b0000_0100);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00);
    want_log.push_back(5); want_log.push_back(6);
    want_log.push_back(0); want_log.push_back(2);
    checkLog("single_wrap");

    // Fairness: all requesting, each grantee drops after two granted cycles
    doReset();
    check_gap = 1;
    for (int k = 0; k < 27; k++) begin
      rq = 8'hFF;
      if (m_busy && m_hold >= 2) rq[m_idx] = 1'b0;
      applyStimulus(1'b0, rq);
    end
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00);
    for (int k = 0; k < 9; k++) want_log.push_back(k % 8);
    checkLog("fairness");

    // Timeout: a single requester never releases
    doReset();
    to_count = 0;
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 8'b0000_1000);
    check_gap = 0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("timeout_pulses", 16'(to_count), 16'd4);
    for (int k = 0; k < 4; k++) want_log.push_back(3);
    checkLog("timeout");

    // Reset during the second granted cycle of idx 2
    doReset();
    applyStimulus(1'b0, 8'b0000_0100);
    applyStimulus(1'b0, 8'b0000_0100);
    applyStimulus(1'b1, 8'b0000_0100);
    applyStimulus(1'b0, 8'b0000_0101);
    applyStimulus(1'b0, 8'h00);
    want_log.push_back(2); want_log.push_back(0);
    checkLog("reset_mid_a");

    // Same, but a pointer left at 3 would pick idx 3 instead of 2
    doReset();
    applyStimulus(1'b0, 8'b0000_0100);
    applyStimulus(1'b0, 8'b0000_0100);
    applyStimulus(1'b1, 8'b0000_0100);
    applyStimulus(1'b0, 8'b0000_1100);
    applyStimulus(1'b0, 8'h00);
    want_log.push_back(2); want_log.push_back(2);
    checkLog("reset_mid_b");

    // Random traffic with sticky requests and occasional reset
    doReset();
    rq = 8'h00;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom_range(0, 255));
      applyStimulus($urandom_range(0, 39) == 0, rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
